dmem_bus_ctrl: RTL and testbench
================================

# dmem_bus_ctrl

Synthesizable data-side memory controller on the core's data bus (DAD/DDT/MREQ/WRITE/SIZE/ACKD_n). It takes one request at a time and returns ACKD_n after a programmable latency. It serves a byte-addressed on-chip data RAM and two memory-mapped ports: a console byte stream (STDOUT) and a program-exit flag (EXIT). It replaces behavioural memory models so that core + memory can be synthesized and simulated as one unit.

## Interface
- DMEM_START, 32'h0800_0000, base byte address of data RAM
- DMEM_WORDS, 4096, RAM depth in 32-bit words
- DMEM_LATENCY, 1, cycles from request acceptance to ACK (legal range 1..15)
- STDOUT_ADDR, 32'hf000_0000, console byte port
- EXIT_ADDR, 32'hff00_0000, exit port
- CON_DEPTH, 8, console FIFO entries (power of two)

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-low
- MREQ  in  1  request valid; core holds DAD/WRITE/SIZE/DDT stable until ACK
- WRITE  in  1  1 = store, 0 = load
- SIZE  in  2  00 word, 01 half, 10 byte
- DAD  in  32  byte address
- DDT  inout  32  store data in; load data driven only during a load ACK cycle, high-Z otherwise
- ACKD_n  out  1  active-low ACK, exactly one cycle per request
- con_valid  out  1  console byte available
- con_data  out  8  console byte (FIFO head)
- con_ready  in  1  consumer pops on con_valid & con_ready
- halt  out  1  sticky; set by any store to EXIT_ADDR
- err  out  1  sticky access error (see Configuration)

## Operation
- FSM states: IDLE, WAIT, ACK.
- IDLE → WAIT when MREQ=1. Latch WRITE/SIZE/DAD/DDT and load cnt=DMEM_LATENCY-1.
- WAIT: decrement cnt each cycle. At cnt==0, perform the access and go to ACK.
  - Exception: a console store with a full FIFO holds in WAIT until space exists.
- ACK: ACKD_n=0 for one cycle, then IDLE. New requests are accepted only in IDLE, so there is at least one idle cycle between ACKs.
- Lane mapping, with b = DAD - DMEM_START and w = {b[31:2],2'b00}:
  - Word: bytes w..w+3, MSB first, on DDT[31:0].
  - Half: bytes (w+2-b[1:0]) and the next byte, on DDT[15:0].
  - Byte: byte (w+3-b[1:0]), on DDT[7:0].
  - Loads zero-extend. Stores use the same byte positions and the same DDT bits.
- Store to STDOUT_ADDR (any SIZE): push DDT[7:0] into the console FIFO.
- Store to EXIT_ADDR: set halt. Nothing is written.
- Loads from STDOUT/EXIT return 0.
- The FIFO pops on con_valid & con_ready. A simultaneous push and pop in the same cycle is legal and leaves the count unchanged.

## Timing
- Reset values (async on rst=0): state IDLE, ACKD_n=1, DDT high-Z, con_valid=0, con_data=0, halt=0, err=0, FIFO empty. RAM contents are not reset.
- Latency: request sampled at edge k, ACKD_n low during cycle k+DMEM_LATENCY.
- The load data on DDT is registered, valid during the whole ACK cycle.
- Store visibility: a load accepted after the store's ACK sees the new data.
- Reset asserted mid-request aborts the request: no ACK, and no RAM write if the RAM write has not yet occurred.
- MREQ deasserted before ACK is a protocol violation. The behaviour is undefined and is not checked.

## Configuration
- DMEM_BOUNDS_CHECK_EN defined:
  - An address outside [DMEM_START, DMEM_START+4*DMEM_WORDS) that is not STDOUT/EXIT sets err.
  - The store is dropped; a load returns 0. The ACK is still issued.
- DMEM_BOUNDS_CHECK_EN undefined:
  - The word index wraps modulo DMEM_WORDS.
  - err stays 0.

## Structure
- Package dbus_pkg holds:
  - SIZE encodings (SZ_WORD/SZ_HALF/SZ_BYTE)
  - the FSM state enum
  - default STDOUT_ADDR/EXIT_ADDR constants
- Sub-module dmem_sram:
  - DMEM_WORDS×32 RAM with synchronous read and a 4-bit byte write enable
  - lane 3 = bits 31:24 = lowest byte address
- The console FIFO stays inline (pointer + count).

## Test plan
- Store word 32'hdeadbeef to 0x0800_0010, then load word from the same address. ACKD_n is low exactly 1 cycle after each request (LATENCY=1), and DDT reads back 32'hdeadbeef.
- Read back the same word with narrower loads:
  - half at 0x0800_0010 returns 32'h0000beef
  - half at 0x0800_0012 returns 32'h0000dead
  - byte at 0x0800_0011 returns 32'h000000be
- Store byte 8'h41 to STDOUT_ADDR nine times with con_ready=0 and CON_DEPTH=8:
  - the 8th store is ACKed and con_valid=1
  - the 9th store is not ACKed until con_ready=1 for one cycle; it is then ACKed on the following ACK cycle
- Store to EXIT_ADDR: halt rises with the ACK and stays 1 until rst=0.
- With DMEM_LATENCY=4: ACKD_n falls 4 cycles after acceptance. Asserting rst=0 two cycles after acceptance gives no ACK, ACKD_n=1, and RAM unchanged.
- With DMEM_BOUNDS_CHECK_EN, store to 0x0000_1000: ACK is issued, err=1, and the RAM word at index 0x1000>>2 modulo depth is unchanged.

Source files
------------

// File: rtl/dbus_pkg.sv
// Shared definitions for the data-bus memory controller.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package dbus_pkg;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    localparam logic [31:0] STDOUT_ADDR_DEF = 32'hf000_0000;
    localparam logic [31:0] EXIT_ADDR_DEF   = 32'hff00_0000;

    // Byte lanes touched by an access. Lane 3 holds the lowest byte address,
    // and a half/byte at offset o sits at the bottom of the word shifted by o lanes.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] m;
        case (size)
            SZ_WORD: m = 4'b1111;
            SZ_HALF: m = 4'b0011 << off;
            default: m = 4'b0001 << off;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/dmem_sram.sv
// Single-port WORDS x 32 data RAM with per-lane write enables, lane 3 = bits 31:24.
// Latency: read data registered, valid the cycle after i_en.
// Backpressure: none; accepts an access every cycle.
module dmem_sram #(
    parameter int WORDS = 4096
) (
    input  logic                     clk,
    input  logic                     i_en,
    input  logic [3:0]               i_we,
    input  logic [$clog2(WORDS)-1:0] i_addr,
    input  logic [31:0]              i_wdat,
    output logic [31:0]              o_rdat
);

    logic [31:0] r_mem [WORDS];

    // Lane-masked write and read-before-write registered read; contents are never reset.
    always_ff @(posedge clk) begin
        if (i_en) begin
            for (int i = 0; i < 4; i++) begin
                if (i_we[i]) begin
                    r_mem[i_addr][8*i +: 8] <= i_wdat[8*i +: 8];
                end
            end
            o_rdat <= r_mem[i_addr];
        end
    end

endmodule

// File: rtl/dmem_bus_ctrl.sv
// Data-bus controller: RAM, console byte FIFO and exit flag behind one MREQ/ACKD_n bus.
// Latency: ACKD_n low DMEM_LATENCY cycles after MREQ is sampled in IDLE, for one cycle.
// Backpressure: a console store into a full FIFO stalls in WAIT until a pop frees a slot.
// Optional address bounds checking is enabled by defining DMEM_BOUNDS_CHECK_EN.
module dmem_bus_ctrl
    import dbus_pkg::*;
#(
    parameter logic [31:0] DMEM_START   = 32'h0800_0000,
    parameter int          DMEM_WORDS   = 4096,
    parameter int          DMEM_LATENCY = 1,
    parameter logic [31:0] STDOUT_ADDR  = STDOUT_ADDR_DEF,
    parameter logic [31:0] EXIT_ADDR    = EXIT_ADDR_DEF,
    parameter int          CON_DEPTH    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MREQ,
    input  logic        WRITE,
    input  logic [1:0]  SIZE,
    input  logic [31:0] DAD,
    inout  wire  [31:0] DDT,
    output logic        ACKD_n,
    output logic        con_valid,
    output logic [7:0]  con_data,
    input  logic        con_ready,
    output logic        halt,
    output logic        err
);

    localparam int AW = $clog2(DMEM_WORDS);
    localparam int CW = $clog2(CON_DEPTH);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_write;
    logic [1:0]  r_size;
    logic [31:0] r_addr;
    logic [31:0] r_wdat;
    logic        r_ack_n;
    logic        r_ld_oe;
    logic        r_halt;
    logic        r_err;

    logic [7:0]  r_fifo [CON_DEPTH];
    logic [CW-1:0] r_wr_ptr;
    logic [CW-1:0] r_rd_ptr;
    logic [CW:0]   r_count;

    logic [AW+1:0] w_b_lo;
    logic [4:0]    w_sh;
    logic          w_is_con;
    logic          w_is_exit;
    logic          w_ram_ok;
    logic          w_bad;
    logic          w_pop;
    logic          w_space;
    logic          w_fire;
    logic          w_push;
    logic [31:0]   w_rdat;
    logic [31:0]   w_rsh;
    logic [31:0]   w_wdat;
    logic [31:0]   w_ld_dat;

    // Offset from the RAM base; only the low bits matter for lane and word index.
    assign w_b_lo    = r_addr[AW+1:0] - DMEM_START[AW+1:0];
    assign w_sh      = {w_b_lo[1:0], 3'b000};
    assign w_is_con  = (r_addr == STDOUT_ADDR);
    assign w_is_exit = (r_addr == EXIT_ADDR);

`ifdef DMEM_BOUNDS_CHECK_EN
    logic w_in_range;
    assign w_in_range = (r_addr - DMEM_START) < 32'(4 * DMEM_WORDS);
    assign w_ram_ok   = w_in_range && !w_is_con && !w_is_exit;
    assign w_bad      = !w_in_range && !w_is_con && !w_is_exit;
`else
    assign w_ram_ok   = !w_is_con && !w_is_exit;
    assign w_bad      = 1'b0;
`endif

    // A pop in the same cycle frees the slot, so a full FIFO can still take a push.
    assign w_pop   = (r_count != '0) && con_ready;
    assign w_space = (r_count != (CW+1)'(CON_DEPTH)) || w_pop;
    assign w_fire  = (r_state == ST_WAIT) && (r_cnt == 4'd0)
                     && !(r_write && w_is_con && !w_space);
    assign w_push  = w_fire && r_write && w_is_con;

    assign w_wdat  = (r_size == SZ_WORD) ? r_wdat : (r_wdat << w_sh);

    dmem_sram #(.WORDS(DMEM_WORDS)) u_sram (
        .clk    (clk),
        .i_en   (w_fire && w_ram_ok),
        .i_we   (r_write ? lane_mask(r_size, w_b_lo[1:0]) : 4'b0000),
        .i_addr (w_b_lo[AW+1:2]),
        .i_wdat (w_wdat),
        .o_rdat (w_rdat)
    );

    // Load data: lane select and zero extension on the registered RAM output.
    always_comb begin
        w_rsh    = w_rdat >> w_sh;
        w_ld_dat = 32'h0;
        if (w_ram_ok) begin
            case (r_size)
                SZ_WORD: w_ld_dat = w_rdat;
                SZ_HALF: w_ld_dat = {16'h0, w_rsh[15:0]};
                default: w_ld_dat = {24'h0, w_rsh[7:0]};
            endcase
        end
    end

    assign DDT       = r_ld_oe ? w_ld_dat : {32{1'bz}};
    assign ACKD_n    = r_ack_n;
    assign halt      = r_halt;
    assign err       = r_err;
    assign con_valid = (r_count != '0);
    assign con_data  = (r_count != '0) ? r_fifo[r_rd_ptr] : 8'h00;

    // Request FSM: latch in IDLE, count down in WAIT, one-cycle ACK with registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_write <= 1'b0;
            r_size  <= SZ_WORD;
            r_addr  <= 32'h0;
            r_wdat  <= 32'h0;
            r_ack_n <= 1'b1;
            r_ld_oe <= 1'b0;
            r_halt  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_ack_n <= 1'b1;
            r_ld_oe <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (MREQ) begin
                        r_write <= WRITE;
                        r_size  <= SIZE;
                        r_addr  <= DAD;
                        r_wdat  <= DDT;
                        r_cnt   <= 4'(DMEM_LATENCY - 1);
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else if (w_fire) begin
                        r_state <= ST_ACK;
                        r_ack_n <= 1'b0;
                        r_ld_oe <= !r_write;
                        if (r_write && w_is_exit) r_halt <= 1'b1;
                        if (w_bad)                r_err  <= 1'b1;
                    end
                end
                ST_ACK:  r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Console FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Console FIFO storage; only the low data byte of a console store is kept.
    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wr_ptr] <= r_wdat[7:0];
    end

endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// Scoreboard bench: one controller at latency 1, one at latency 4.
// Requests push expected ACK timing/data/flags; a monitor pops and compares on each ACK.
// Console, exit, bounds and mid-request reset scenarios use hand-computed values.
`timescale 1ns/1ps
module tb_dmem_bus_ctrl;

    typedef struct {
        logic        is_load;
        logic [31:0] data;
        int          ack_cyc;
        logic        halt;
        logic        err;
    } exp_t;

    localparam logic [31:0] STDOUT = 32'hf000_0000;
    localparam logic [31:0] EXITA  = 32'hff00_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst_n   [2];
    logic        mreq    [2];
    logic        wr      [2];
    logic [1:0]  sz      [2];
    logic [31:0] dad     [2];
    logic        drv_en  [2];
    logic [31:0] drv_dat [2];
    logic        con_r   [2];
    logic        exp_halt[2];
    logic        exp_err [2];

    wire [31:0] ddt0, ddt1;
    wire [1:0]  ack_n, con_v, hlt, er;
    wire [7:0]  con_d0, con_d1;

    assign ddt0 = drv_en[0] ? drv_dat[0] : {32{1'bz}};
    assign ddt1 = drv_en[1] ? drv_dat[1] : {32{1'bz}};

    dmem_bus_ctrl #(.DMEM_LATENCY(1)) u_dut0 (
        .clk(clk), .rst(rst_n[0]), .MREQ(mreq[0]), .WRITE(wr[0]), .SIZE(sz[0]),
        .DAD(dad[0]), .DDT(ddt0), .ACKD_n(ack_n[0]), .con_valid(con_v[0]),
        .con_data(con_d0), .con_ready(con_r[0]), .halt(hlt[0]), .err(er[0])
    );

    dmem_bus_ctrl #(.DMEM_LATENCY(4)) u_dut1 (
        .clk(clk), .rst(rst_n[1]), .MREQ(mreq[1]), .WRITE(wr[1]), .SIZE(sz[1]),
        .DAD(dad[1]), .DDT(ddt1), .ACKD_n(ack_n[1]), .con_valid(con_v[1]),
        .con_data(con_d1), .con_ready(con_r[1]), .halt(hlt[1]), .err(er[1])
    );

    exp_t q0[$];
    exp_t q1[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every ACK must match the oldest outstanding expectation of its DUT.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (ack_n[i] === 1'b0) begin
                    if ((i == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_ack: dut%0d acked at cycle %0d with nothing outstanding", i, cyc);
                    end else begin
                        e = (i == 0) ? q0.pop_front() : q1.pop_front();
                        if (e.ack_cyc >= 0) check("ack_latency", 32'(cyc), 32'(e.ack_cyc));
                        if (e.is_load) check("load_data", (i == 0) ? ddt0 : ddt1, e.data);
                        check("halt_at_ack", 32'(hlt[i]), 32'(e.halt));
                        check("err_at_ack", 32'(er[i]), 32'(e.err));
                    end
                end
            end
        end
    end

    // Drive a request and record what its ACK must look like (lat < 0: timing unchecked).
    task automatic issue(input int i, input logic w, input logic [1:0] s, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] exp_d, input int lat);
        exp_t e;
        @(negedge clk);
        mreq[i] = 1'b1; wr[i] = w; sz[i] = s; dad[i] = a; drv_dat[i] = d; drv_en[i] = w;
        e.is_load = !w;
        e.data    = exp_d;
        e.ack_cyc = (lat < 0) ? -1 : cyc + 1 + lat;
        e.halt    = exp_halt[i];
        e.err     = exp_err[i];
        if (i == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    task automatic release_bus(input int i);
        mreq[i] = 1'b0;
        drv_en[i] = 1'b0;
    endtask

    task automatic timeout(input int i, input string name);
        checks++;
        errors++;
        $display("FAIL %s: dut%0d gave no ACK within the cycle budget", name, i);
        if (i == 0) void'(q0.pop_back()); else void'(q1.pop_back());
    endtask

    task automatic do_req(input int i, input logic w, input logic [1:0] s, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] exp_d, input int lat);
        bit seen = 0;
        issue(i, w, s, a, d, exp_d, lat);
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            if (ack_n[i] === 1'b0) seen = 1;
        end
        if (!seen) timeout(i, "req_ack");
        release_bus(i);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int  acks;
        bit  seen;
        for (int i = 0; i < 2; i++) begin
            rst_n[i] = 1'b0; mreq[i] = 1'b0; wr[i] = 1'b0; sz[i] = 2'b00; dad[i] = 32'h0;
            drv_en[i] = 1'b0; drv_dat[i] = 32'h0; con_r[i] = 1'b0;
            exp_halt[i] = 1'b0; exp_err[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        check("rst_ack_n",     32'(ack_n), 32'h3);
        check("rst_con_valid", 32'(con_v), 32'h0);
        check("rst_con_data",  32'(con_d0), 32'h0);
        check("rst_halt",      32'(hlt),   32'h0);
        check("rst_err",       32'(er),    32'h0);
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;

        // Word store/load and narrow reads of the same word.
        do_req(0, 1'b1, 2'b00, 32'h0800_0010, 32'hdeadbeef, 32'h0, 1);
        @(negedge clk);
        check("ack_one_cycle", 32'(ack_n[0]), 32'h1);
        do_req(0, 1'b0, 2'b00, 32'h0800_0010, 32'h0, 32'hdeadbeef, 1);
        do_req(0, 1'b0, 2'b01, 32'h0800_0010, 32'h0, 32'h0000beef, 1);
        do_req(0, 1'b0, 2'b01, 32'h0800_0012, 32'h0, 32'h0000dead, 1);
        do_req(0, 1'b0, 2'b10, 32'h0800_0011, 32'h0, 32'h0000_00be, 1);
        do_req(0, 1'b0, 2'b10, 32'h0800_0013, 32'h0, 32'h0000_00de, 1);
        do_req(0, 1'b0, 2'b10, 32'h0800_0010, 32'h0, 32'h0000_00ef, 1);
        // Narrow stores: byte at +2 hits the second-lowest address lane, half at +0 the low half.
        do_req(0, 1'b1, 2'b10, 32'h0800_0012, 32'hffff_ff5a, 32'h0, 1);
        do_req(0, 1'b0, 2'b00, 32'h0800_0010, 32'h0, 32'hde5abeef, 1);
        do_req(0, 1'b1, 2'b01, 32'h0800_0010, 32'hffff_1234, 32'h0, 1);
        do_req(0, 1'b0, 2'b00, 32'h0800_0010, 32'h0, 32'hde5a1234, 1);
        // Last RAM word.
        do_req(0, 1'b1, 2'b00, 32'h0800_3ffc, 32'h0bad_cafe, 32'h0, 1);
        do_req(0, 1'b0, 2'b00, 32'h0800_3ffc, 32'h0, 32'h0bad_cafe, 1);

        // Console: eight stores fill the FIFO, upper data bits ignored.
        for (int n = 0; n < 8; n++)
            do_req(0, 1'b1, 2'b00, STDOUT, 32'haabbcc00 | 32'(8'h41 + n), 32'h0, 1);
        check("con_valid_full", 32'(con_v[0]), 32'h1);
        check("con_head_full",  32'(con_d0),   32'h41);
        do_req(0, 1'b0, 2'b00, STDOUT, 32'h0, 32'h0, 1);
        // Ninth store stalls until one pop.
        issue(0, 1'b1, 2'b10, STDOUT, 32'h0000_0049, 32'h0, -1);
        acks = 0;
        repeat (6) begin
            @(negedge clk);
            if (ack_n[0] === 1'b0) acks++;
        end
        check("no_ack_while_full", 32'(acks), 32'h0);
        con_r[0] = 1'b1;
        seen = 0;
        for (int n = 0; n < 8 && !seen; n++) begin
            @(negedge clk);
            con_r[0] = 1'b0;
            if (ack_n[0] === 1'b0) seen = 1;
        end
        if (!seen) timeout(0, "ack_after_pop");
        release_bus(0);
        @(negedge clk);
        con_r[0] = 1'b1;
        for (int j = 0; j < 8; j++) begin
            check("con_drain_valid", 32'(con_v[0]), 32'h1);
            check("con_drain_data",  32'(con_d0),   32'(8'h42 + j));
            @(negedge clk);
        end
        con_r[0] = 1'b0;
        check("con_empty", 32'(con_v[0]), 32'h0);

        // Exit: halt rises with the ACK and sticks.
        exp_halt[0] = 1'b1;
        do_req(0, 1'b1, 2'b00, EXITA, 32'h0000_0001, 32'h0, 1);
        do_req(0, 1'b0, 2'b00, EXITA, 32'h0, 32'h0, 1);
        do_req(0, 1'b0, 2'b00, 32'h0800_0010, 32'h0, 32'hde5a1234, 1);

        // Out-of-range address 0x0000_1000 lands on word index 0x400 when wrapping.
        do_req(0, 1'b1, 2'b00, 32'h0800_1000, 32'h5555aaaa, 32'h0, 1);
`ifdef DMEM_BOUNDS_CHECK_EN
        exp_err[0] = 1'b1;
        do_req(0, 1'b1, 2'b00, 32'h0000_1000, 32'h7777_7777, 32'h0, 1);
        do_req(0, 1'b0, 2'b00, 32'h0800_1000, 32'h0, 32'h5555aaaa, 1);
        do_req(0, 1'b0, 2'b00, 32'h0000_1000, 32'h0, 32'h0, 1);
`else
        do_req(0, 1'b1, 2'b00, 32'h0000_1000, 32'h7777_7777, 32'h0, 1);
        do_req(0, 1'b0, 2'b00, 32'h0800_1000, 32'h0, 32'h7777_7777, 1);
`endif

        // Reset clears the sticky flags.
        @(negedge clk);
        rst_n[0] = 1'b0;
        exp_halt[0] = 1'b0;
        exp_err[0] = 1'b0;
        @(negedge clk);
        check("halt_after_rst", 32'(hlt[0]), 32'h0);
        check("err_after_rst",  32'(er[0]),  32'h0);
        rst_n[0] = 1'b1;

        // Latency 4, then a store aborted by reset two cycles after acceptance.
        do_req(1, 1'b1, 2'b00, 32'h0800_0020, 32'h1122_3344, 32'h0, 4);
        do_req(1, 1'b0, 2'b00, 32'h0800_0020, 32'h0, 32'h1122_3344, 4);
        @(negedge clk);
        mreq[1] = 1'b1; wr[1] = 1'b1; sz[1] = 2'b00; dad[1] = 32'h0800_0020;
        drv_dat[1] = 32'hcafe_f00d; drv_en[1] = 1'b1;
        acks = 0;
        repeat (2) begin
            @(negedge clk);
            if (ack_n[1] === 1'b0) acks++;
        end
        rst_n[1] = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (ack_n[1] === 1'b0) acks++;
        end
        check("no_ack_after_abort", 32'(acks), 32'h0);
        release_bus(1);
        @(negedge clk);
        rst_n[1] = 1'b1;
        @(negedge clk);
        check("ack_n_idle_after_abort", 32'(ack_n[1]), 32'h1);
        do_req(1, 1'b0, 2'b00, 32'h0800_0020, 32'h0, 32'h1122_3344, 4);

        repeat (3) @(negedge clk);
        check("q0_drained", 32'(q0.size()), 32'h0);
        check("q1_drained", 32'(q1.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
